jk_bank_arbiter: RTL and testbench

- Shares one bank of WIDTH JK-style flip-flops between NREQ requesters.
- Each requester posts a single-bit command: hold, clear, set or toggle, addressed to one bit.
- A round-robin arbiter grants one requester per clock and applies its command to the addressed bit with JK semantics.
- Sits between control agents (e.g. FSMs, software shadow regs) and a shared status/flag register bank.

---
 rtl/jk_bank_arbiter_if.sv | 26 ++
 rtl/jk_bank_arbiter.sv | 126 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_arbiter_if.sv
// Requester/arbiter bundle for the shared JK flag bank.
// master = requester side, slave = arbiter side.
interface jk_bank_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*2-1:0]  cmd;
    logic [NREQ-1:0]    gnt;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   q_bar;
    logic               busy;
    logic               addr_err;

    modport master (
        output req, addr, cmd,
        input  gnt, q, q_bar, busy, addr_err
    );

    modport slave (
        input  req, addr, cmd,
        output gnt, q, q_bar, busy, addr_err
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin shared JK flip-flop bank, one command applied per clock.
// Optional JK_BANK_CONFLICT_EN adds a same-bit command conflict flag.
module jk_bank_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input logic clk,
    input logic n_rst,
    jk_bank_arbiter_if.slave bus
`ifdef JK_BANK_CONFLICT_EN
    ,
    output logic conflict
`endif
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic             found;
    logic [AW-1:0]    b;
    logic [1:0]       jk;
    logic             valid;
    logic [NREQ-1:0]  gnt_nxt;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic             busy;
    logic             addr_err;

    // Priority distance from ptr+1; smallest distance wins.
    always_comb begin
        int best;
        int d;
        best  = NREQ;
        d     = 0;
        found = 1'b0;
        win   = ptr;
        b     = '0;
        jk    = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(ptr) - 1;
            if (d < 0)
                d = d + NREQ;
            if (bus.req[i] && d < best) begin
                best  = d;
                found = 1'b1;
                win   = PW'(i);
                b     = bus.addr[i*AW +: AW];
                jk    = bus.cmd[i*2 +: 2];
            end
        end
    end

    assign valid = int'(b) < WIDTH;

    always_comb begin
        gnt_nxt = '0;
        for (int i = 0; i < NREQ; i++)
            gnt_nxt[i] = found && (win == PW'(i));
    end

    always_comb begin
        q_nxt = q;
        for (int i = 0; i < WIDTH; i++) begin
            if (found && valid && int'(b) == i) begin
                unique case (jk)
                    2'b00: q_nxt[i] = q[i];
                    2'b01: q_nxt[i] = 1'b0;
                    2'b10: q_nxt[i] = 1'b1;
                    2'b11: q_nxt[i] = ~q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr      <= PW'(NREQ - 1);
            gnt      <= '0;
            q        <= '0;
            busy     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            gnt      <= gnt_nxt;
            q        <= q_nxt;
            busy     <= found;
            addr_err <= found && !valid;
            if (found)
                ptr <= win;
        end
    end

`ifdef JK_BANK_CONFLICT_EN
    logic conf_nxt;

    // Two live requests, same valid bit, different non-hold commands.
    always_comb begin
        conf_nxt = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (bus.req[i] && bus.req[j] &&
                    bus.addr[i*AW +: AW] == bus.addr[j*AW +: AW] &&
                    int'(bus.addr[i*AW +: AW]) < WIDTH &&
                    bus.cmd[i*2 +: 2] != 2'b00 &&
                    bus.cmd[j*2 +: 2] != 2'b00 &&
                    bus.cmd[i*2 +: 2] != bus.cmd[j*2 +: 2])
                    conf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            conflict <= 1'b0;
        else
            conflict <= conf_nxt;
    end
`endif

    assign bus.gnt      = gnt;
    assign bus.q        = q;
    assign bus.q_bar    = ~q;
    assign bus.busy     = busy;
    assign bus.addr_err = addr_err;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: vector table, directed corners, random vs model.
// Two instances: 2x8 bank and 3x6 bank (out-of-range addresses).
`timescale 1ns/1ps
module tb_jk_bank_arbiter;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    jk_bank_arbiter_if #(.NREQ(2), .WIDTH(8), .AW(AW)) ba();
    jk_bank_arbiter_if #(.NREQ(3), .WIDTH(6), .AW(AW)) bb();

`ifdef JK_BANK_CONFLICT_EN
    logic conf_a;
    logic conf_b;
`endif

    jk_bank_arbiter #(.NREQ(2), .WIDTH(8), .AW(AW)) u_a (
        .clk(clk),
        .n_rst(n_rst),
        .bus(ba.slave)
`ifdef JK_BANK_CONFLICT_EN
        ,
        .conflict(conf_a)
`endif
    );

    jk_bank_arbiter #(.NREQ(3), .WIDTH(6), .AW(AW)) u_b (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bb.slave)
`ifdef JK_BANK_CONFLICT_EN
        ,
        .conflict(conf_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mq_a;
    logic [7:0] mq_b;
    int         lg_a;
    int         lg_b;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [5:0] addr;
        logic [3:0] cmd;
        logic [1:0] gnt;
        logic [7:0] q;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic [1:0] r,
                                input logic [2:0] a1, input logic [2:0] a0,
                                input logic [1:0] c1, input logic [1:0] c0,
                                input logic [1:0] g, input logic [7:0] qv,
                                input logic bz);
        vec_t v;
        v.rst  = rst;
        v.req  = r;
        v.addr = {a1, a0};
        v.cmd  = {c1, c0};
        v.gnt  = g;
        v.q    = qv;
        v.busy = bz;
        tbl.push_back(v);
    endfunction

    // Reference: last-granted index lg; scan lg+1, lg+2, ... modulo nreq.
    task automatic mstep(input int nreq, input int width,
                         input logic [7:0] rq, input logic [23:0] ad,
                         input logic [15:0] cm, inout int lg,
                         inout logic [7:0] mq, output logic [7:0] eg,
                         output logic eb, output logic ee,
                         output logic ec);
        int w;
        int bi;
        logic [1:0] c;
        w  = -1;
        eg = '0;
        eb = 1'b0;
        ee = 1'b0;
        ec = 1'b0;
        for (int k = 1; k <= nreq; k++)
            if (w < 0 && rq[(lg + k) % nreq])
                w = (lg + k) % nreq;
        for (int i = 0; i < nreq; i++)
            for (int j = i + 1; j < nreq; j++)
                if (rq[i] && rq[j] &&
                    ad[i*AW +: AW] == ad[j*AW +: AW] &&
                    int'(ad[i*AW +: AW]) < width &&
                    cm[i*2 +: 2] != 2'b00 && cm[j*2 +: 2] != 2'b00 &&
                    cm[i*2 +: 2] != cm[j*2 +: 2])
                    ec = 1'b1;
        if (w >= 0) begin
            eg = 8'(1) << w;
            eb = 1'b1;
            lg = w;
            bi = int'(ad[w*AW +: AW]);
            c  = cm[w*2 +: 2];
            if (bi >= width)
                ee = 1'b1;
            else if (c == 2'b01)
                mq[bi] = 1'b0;
            else if (c == 2'b10)
                mq[bi] = 1'b1;
            else if (c == 2'b11)
                mq[bi] = ~mq[bi];
        end
    endtask

    task automatic tick(input logic [1:0] ra, input logic [5:0] aa,
                        input logic [3:0] ca, input logic [2:0] rb,
                        input logic [8:0] ab, input logic [5:0] cb);
        logic [7:0] eg;
        logic eb;
        logic ee;
        logic ec;
        logic [7:0] nqa;
        logic [5:0] nqb;
        @(negedge clk);
        ba.req  = ra;
        ba.addr = aa;
        ba.cmd  = ca;
        bb.req  = rb;
        bb.addr = ab;
        bb.cmd  = cb;
        @(posedge clk);
        #1;
        mstep(2, 8, 8'(ra), 24'(aa), 16'(ca), lg_a, mq_a, eg, eb, ee, ec);
        nqa = ~mq_a;
        chk("a_gnt", 32'(ba.gnt), 32'(eg));
        chk("a_q", 32'(ba.q), 32'(mq_a));
        chk("a_qbar", 32'(ba.q_bar), 32'(nqa));
        chk("a_busy", 32'(ba.busy), 32'(eb));
        chk("a_err", 32'(ba.addr_err), 32'(ee));
`ifdef JK_BANK_CONFLICT_EN
        chk("a_conf", 32'(conf_a), 32'(ec));
`endif
        mstep(3, 6, 8'(rb), 24'(ab), 16'(cb), lg_b, mq_b, eg, eb, ee, ec);
        nqb = ~mq_b[5:0];
        chk("b_gnt", 32'(bb.gnt), 32'(eg));
        chk("b_q", 32'(bb.q), 32'(mq_b[5:0]));
        chk("b_qbar", 32'(bb.q_bar), 32'(nqb));
        chk("b_busy", 32'(bb.busy), 32'(eb));
        chk("b_err", 32'(bb.addr_err), 32'(ee));
`ifdef JK_BANK_CONFLICT_EN
        chk("b_conf", 32'(conf_b), 32'(ec));
`endif
    endtask

    // Asserted between edges so the clear must be asynchronous.
    task automatic mid_reset();
        #1;
        n_rst   = 1'b0;
        ba.req  = '0;
        ba.addr = '0;
        ba.cmd  = '0;
        bb.req  = '0;
        bb.addr = '0;
        bb.cmd  = '0;
        #1;
        chk("rst_a_q", 32'(ba.q), 32'h0);
        chk("rst_a_gnt", 32'(ba.gnt), 32'h0);
        chk("rst_a_busy", 32'(ba.busy), 32'h0);
        chk("rst_a_err", 32'(ba.addr_err), 32'h0);
        chk("rst_b_q", 32'(bb.q), 32'h0);
        chk("rst_b_gnt", 32'(bb.gnt), 32'h0);
`ifdef JK_BANK_CONFLICT_EN
        chk("rst_a_conf", 32'(conf_a), 32'h0);
`endif
        mq_a = '0;
        mq_b = '0;
        lg_a = 1;
        lg_b = 2;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    logic [2:0] rot [4];

    initial begin
        rot[0] = 3'b001;
        rot[1] = 3'b010;
        rot[2] = 3'b100;
        rot[3] = 3'b001;

        add(1, 2'b01, 0, 3, 2'b00, 2'b10, 2'b01, 8'h08, 1);
        add(0, 2'b00, 0, 3, 2'b00, 2'b10, 2'b00, 8'h08, 0);
        add(0, 2'b01, 0, 3, 2'b00, 2'b11, 2'b01, 8'h00, 1);
        add(0, 2'b01, 0, 3, 2'b00, 2'b11, 2'b01, 8'h08, 1);
        add(0, 2'b01, 0, 3, 2'b00, 2'b11, 2'b01, 8'h00, 1);
        add(0, 2'b01, 0, 3, 2'b00, 2'b11, 2'b01, 8'h08, 1);
        add(1, 2'b11, 1, 0, 2'b10, 2'b10, 2'b01, 8'h01, 1);
        add(0, 2'b11, 1, 0, 2'b10, 2'b10, 2'b10, 8'h03, 1);
        add(0, 2'b11, 1, 0, 2'b10, 2'b10, 2'b01, 8'h03, 1);
        for (int k = 2; k < 8; k++)
            add(0, 2'b01, 0, 3'(k), 2'b00, 2'b10, 2'b01,
                8'((1 << (k + 1)) - 1), 1);
        add(0, 2'b10, 5, 0, 2'b01, 2'b00, 2'b10, 8'hDF, 1);
        add(0, 2'b10, 5, 0, 2'b00, 2'b00, 2'b10, 8'hDF, 1);
        add(0, 2'b00, 5, 0, 2'b00, 2'b00, 2'b00, 8'hDF, 0);

        mid_reset();

        foreach (tbl[i]) begin
            if (tbl[i].rst)
                mid_reset();
            tick(tbl[i].req, tbl[i].addr, tbl[i].cmd, '0, '0, '0);
            chk($sformatf("v%0d_gnt", i), 32'(ba.gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_q", i), 32'(ba.q), 32'(tbl[i].q));
            chk($sformatf("v%0d_busy", i), 32'(ba.busy),
                32'(tbl[i].busy));
        end

        // Build q=0x5A through requester 1, then reset with gnt=10 live.
        mid_reset();
        tick(2'b10, {3'd1, 3'd0}, 4'b1000, '0, '0, '0);
        tick(2'b10, {3'd3, 3'd0}, 4'b1000, '0, '0, '0);
        tick(2'b10, {3'd4, 3'd0}, 4'b1000, '0, '0, '0);
        tick(2'b10, {3'd6, 3'd0}, 4'b1000, '0, '0, '0);
        chk("pre_rst_q", 32'(ba.q), 32'h5A);
        chk("pre_rst_gnt", 32'(ba.gnt), 32'h2);
        mid_reset();
        tick(2'b11, '0, '0, '0, '0, '0);
        chk("post_rst_gnt", 32'(ba.gnt), 32'h1);

        // Out-of-range bit on the 6-wide bank.
        mid_reset();
        tick('0, '0, '0, 3'b001, 9'd7, 6'b000010);
        chk("oor_gnt", 32'(bb.gnt), 32'h1);
        chk("oor_err", 32'(bb.addr_err), 32'h1);
        chk("oor_q", 32'(bb.q), 32'h0);
        tick('0, '0, '0, '0, '0, '0);
        chk("oor_err_drop", 32'(bb.addr_err), 32'h0);

        // Three-way rotation from reset.
        mid_reset();
        for (int i = 0; i < 4; i++) begin
            tick('0, '0, '0, 3'b111, '0, '0);
            chk($sformatf("rot%0d", i), 32'(bb.gnt), 32'(rot[i]));
        end

`ifdef JK_BANK_CONFLICT_EN
        mid_reset();
        tick(2'b11, {3'd2, 3'd2}, 4'b0110, '0, '0, '0);
        chk("cf_conf", 32'(conf_a), 32'h1);
        chk("cf_gnt0", 32'(ba.gnt), 32'h1);
        chk("cf_q0", 32'(ba.q[2]), 32'h1);
        tick(2'b10, {3'd2, 3'd2}, 4'b0110, '0, '0, '0);
        chk("cf_conf_drop", 32'(conf_a), 32'h0);
        chk("cf_gnt1", 32'(ba.gnt), 32'h2);
        chk("cf_q1", 32'(ba.q[2]), 32'h0);
`endif

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0)
                mid_reset();
            tick(2'($urandom), 6'($urandom), 4'($urandom),
                 3'($urandom), 9'($urandom), 6'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
